// File: rtl/alu_seq.sv
// alu_seq - sequenced switch/button ALU.
//
// Operand A, operand B and the opcode share one switch bank. Each is
// captured when its button is pressed, in the order A -> B -> OP, under a
// small load FSM. Buttons are asynchronous: each goes through a 2-flop
// synchroniser and a rising-edge detector, so a held button loads only once.
// After the opcode is captured, the result and status flags are computed
// once into registered outputs. While the FSM shows the result, B or OP can
// be reloaded, which starts a recompute. Pressing A starts a new sequence.
//
// Ports:
//   i_clk       single clock, rising edge
//   i_reset     synchronous, active-high reset
//   i_switches  shared data/opcode input (opcode = low OP_CODE_SIZE bits)
//   i_btn_A     async button, load operand A
//   i_btn_B     async button, load operand B
//   i_btn_OP    async button, load opcode
//   o_result    registered result
//   o_carry     carry (ADD), borrow (SUB), shifted-out bit (SRA/SRL)
//   o_zero      result is zero (valid opcodes only)
//   o_negative  result MSB
//   o_overflow  signed overflow (ADD/SUB only)
//   o_valid     outputs match the currently held A, B and opcode
//   o_op_err    held opcode is not a supported operation
//   o_state     FSM state for LEDs (0 WAIT_A, 1 WAIT_B, 2 WAIT_OP, 3 RESULT)
module alu_seq #(
    parameter int DATA_WIDTH   = 8,
    parameter int OP_CODE_SIZE = 6
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [DATA_WIDTH-1:0] i_switches,
    input  logic                  i_btn_A,
    input  logic                  i_btn_B,
    input  logic                  i_btn_OP,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic                  o_carry,
    output logic                  o_zero,
    output logic                  o_negative,
    output logic                  o_overflow,
    output logic                  o_valid,
    output logic                  o_op_err,
    output logic [1:0]            o_state
);

    localparam int MSB = DATA_WIDTH - 1;

    localparam logic [OP_CODE_SIZE-1:0] OP_ADD = OP_CODE_SIZE'(6'b100000);
    localparam logic [OP_CODE_SIZE-1:0] OP_SUB = OP_CODE_SIZE'(6'b100010);
    localparam logic [OP_CODE_SIZE-1:0] OP_AND = OP_CODE_SIZE'(6'b100100);
    localparam logic [OP_CODE_SIZE-1:0] OP_OR  = OP_CODE_SIZE'(6'b100101);
    localparam logic [OP_CODE_SIZE-1:0] OP_XOR = OP_CODE_SIZE'(6'b100110);
    localparam logic [OP_CODE_SIZE-1:0] OP_NOR = OP_CODE_SIZE'(6'b100111);
    localparam logic [OP_CODE_SIZE-1:0] OP_SRA = OP_CODE_SIZE'(6'b000011);
    localparam logic [OP_CODE_SIZE-1:0] OP_SRL = OP_CODE_SIZE'(6'b000010);

    typedef enum logic [1:0] {
        WAIT_A  = 2'd0,
        WAIT_B  = 2'd1,
        WAIT_OP = 2'd2,
        RESULT  = 2'd3
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;

    // Bit 0 = A, bit 1 = B, bit 2 = OP
    logic [2:0]              btn_s;
    logic [2:0]              sync1_r;
    logic [2:0]              sync2_r;
    logic [2:0]              prev_r;
    logic [2:0]              pulse_s;

    logic                    load_a_s;
    logic                    load_b_s;
    logic                    load_op_s;
    logic                    calc_req_s;

    logic [DATA_WIDTH-1:0]   a_r;
    logic [DATA_WIDTH-1:0]   b_r;
    logic [OP_CODE_SIZE-1:0] op_r;
    logic                    pending_r;

    logic [DATA_WIDTH:0]     sum_s;
    logic [DATA_WIDTH:0]     diff_s;
    logic [DATA_WIDTH-1:0]   alu_res_s;
    logic                    alu_carry_s;
    logic                    alu_ovf_s;
    logic                    alu_err_s;
    logic                    alu_zero_s;

    assign btn_s   = {i_btn_OP, i_btn_B, i_btn_A};
    // The previous value resets to 0. A button held through reset
    // therefore still gives one pulse after reset is released.
    assign pulse_s = sync2_r & ~prev_r;
    assign o_state = state_r;

    // Button synchronisers and edge-detector history
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync1_r <= 3'b000;
            sync2_r <= 3'b000;
            prev_r  <= 3'b000;
        end else begin
            sync1_r <= btn_s;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r <= WAIT_A;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state and load enables. Pulses the current state does not
    // expect are dropped. In RESULT the priority is A > B > OP.
    always_comb begin
        state_nxt_s = state_r;
        load_a_s    = 1'b0;
        load_b_s    = 1'b0;
        load_op_s   = 1'b0;
        case (state_r)
            WAIT_A: begin
                if (pulse_s[0]) begin
                    load_a_s    = 1'b1;
                    state_nxt_s = WAIT_B;
                end else begin
                    state_nxt_s = WAIT_A;
                end
            end
            WAIT_B: begin
                if (pulse_s[1]) begin
                    load_b_s    = 1'b1;
                    state_nxt_s = WAIT_OP;
                end else begin
                    state_nxt_s = WAIT_B;
                end
            end
            WAIT_OP: begin
                if (pulse_s[2]) begin
                    load_op_s   = 1'b1;
                    state_nxt_s = RESULT;
                end else begin
                    state_nxt_s = WAIT_OP;
                end
            end
            RESULT: begin
                if (pulse_s[0]) begin
                    load_a_s    = 1'b1;
                    state_nxt_s = WAIT_B;
                end else if (pulse_s[1]) begin
                    load_b_s    = 1'b1;
                    state_nxt_s = RESULT;
                end else if (pulse_s[2]) begin
                    load_op_s   = 1'b1;
                    state_nxt_s = RESULT;
                end else begin
                    state_nxt_s = RESULT;
                end
            end
            default: begin
                state_nxt_s = WAIT_A;
            end
        endcase
    end

    // Request a compute on the first cycle after the operands feeding
    // RESULT change
    always_comb begin
        if (state_r == WAIT_OP) begin
            calc_req_s = load_op_s;
        end else if (state_r == RESULT) begin
            calc_req_s = load_b_s | load_op_s;
        end else begin
            calc_req_s = 1'b0;
        end
    end

    // Operand/opcode holding registers and pending-compute flag
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            a_r       <= {DATA_WIDTH{1'b0}};
            b_r       <= {DATA_WIDTH{1'b0}};
            op_r      <= {OP_CODE_SIZE{1'b0}};
            pending_r <= 1'b0;
        end else begin
            if (load_a_s) begin
                a_r <= i_switches;
            end else begin
                a_r <= a_r;
            end
            if (load_b_s) begin
                b_r <= i_switches;
            end else begin
                b_r <= b_r;
            end
            if (load_op_s) begin
                op_r <= i_switches[OP_CODE_SIZE-1:0];
            end else begin
                op_r <= op_r;
            end
            pending_r <= calc_req_s;
        end
    end

    // Combinational ALU on the held operands
    always_comb begin
        sum_s       = {1'b0, a_r} + {1'b0, b_r};
        diff_s      = {1'b0, a_r} - {1'b0, b_r};
        alu_res_s   = {DATA_WIDTH{1'b0}};
        alu_carry_s = 1'b0;
        alu_ovf_s   = 1'b0;
        alu_err_s   = 1'b0;
        case (op_r)
            OP_ADD: begin
                alu_res_s   = sum_s[MSB:0];
                alu_carry_s = sum_s[DATA_WIDTH];
                alu_ovf_s   = (a_r[MSB] == b_r[MSB]) && (sum_s[MSB] != a_r[MSB]);
            end
            OP_SUB: begin
                // Bit DATA_WIDTH of the zero-extended difference is the borrow (A < B).
                alu_res_s   = diff_s[MSB:0];
                alu_carry_s = diff_s[DATA_WIDTH];
                alu_ovf_s   = (a_r[MSB] != b_r[MSB]) && (diff_s[MSB] != a_r[MSB]);
            end
            OP_AND: alu_res_s = a_r & b_r;
            OP_OR:  alu_res_s = a_r | b_r;
            OP_XOR: alu_res_s = a_r ^ b_r;
            OP_NOR: alu_res_s = ~(a_r | b_r);
            OP_SRA: begin
                alu_res_s   = {a_r[MSB], a_r[MSB:1]};
                alu_carry_s = a_r[0];
            end
            OP_SRL: begin
                alu_res_s   = {1'b0, a_r[MSB:1]};
                alu_carry_s = a_r[0];
            end
            default: begin
                alu_err_s = 1'b1;
            end
        endcase
        // An illegal opcode reports zero=0 even though the result is 0
        alu_zero_s = ~alu_err_s & (alu_res_s == {DATA_WIDTH{1'b0}});
    end

    // Result/flag registers. They hold their value outside a compute cycle.
    // o_valid falls on any load and rises on a compute.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_result   <= {DATA_WIDTH{1'b0}};
            o_carry    <= 1'b0;
            o_zero     <= 1'b0;
            o_negative <= 1'b0;
            o_overflow <= 1'b0;
            o_op_err   <= 1'b0;
            o_valid    <= 1'b0;
        end else begin
            if (pending_r) begin
                o_result   <= alu_res_s;
                o_carry    <= alu_carry_s;
                o_zero     <= alu_zero_s;
                o_negative <= alu_res_s[MSB];
                o_overflow <= alu_ovf_s;
                o_op_err   <= alu_err_s;
            end else begin
                o_result   <= o_result;
                o_carry    <= o_carry;
                o_zero     <= o_zero;
                o_negative <= o_negative;
                o_overflow <= o_overflow;
                o_op_err   <= o_op_err;
            end
            if (load_a_s || load_b_s || load_op_s) begin
                o_valid <= 1'b0;
            end else if (pending_r) begin
                o_valid <= 1'b1;
            end else begin
                o_valid <= o_valid;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (DATA_WIDTH=8, OP_CODE_SIZE=6).
// The reference model tracks, for each button, the value sampled on recent
// clock edges. A load happens two edges after a 0->1 sample. The ALU result
// is derived with plain integer arithmetic.
module tb_alu_seq;

    logic       clk;
    logic       rst;
    logic [7:0] sw;
    logic       btn_a;
    logic       btn_b;
    logic       btn_op;
    logic [7:0] res;
    logic       carry;
    logic       zero;
    logic       neg;
    logic       ovf;
    logic       valid;
    logic       op_err;
    logic [1:0] state;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    // Reference model state
    int m_state, m_a, m_b, m_op, m_res, m_c, m_z, m_n, m_v, m_valid, m_err, m_pend;
    bit [2:0] smp0, smp1, smp2;   // button samples from 1, 2 and 3 edges ago

    alu_seq #(.DATA_WIDTH(8), .OP_CODE_SIZE(6)) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_switches (sw),
        .i_btn_A    (btn_a),
        .i_btn_B    (btn_b),
        .i_btn_OP   (btn_op),
        .o_result   (res),
        .o_carry    (carry),
        .o_zero     (zero),
        .o_negative (neg),
        .o_overflow (ovf),
        .o_valid    (valid),
        .o_op_err   (op_err),
        .o_state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_alu(input int a, input int b, input int op,
                             output int r, output int c, output int z,
                             output int n, output int v, output int e);
        int sa, sb, t;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        r = 0; c = 0; v = 0; e = 0;
        case (op)
            32: begin t = a + b; r = t % 256; c = (t > 255); t = sa + sb; v = (t > 127 || t < -128); end
            34: begin r = (a - b + 256) % 256; c = (a < b); t = sa - sb; v = (t > 127 || t < -128); end
            36: r = a & b;
            37: r = a | b;
            38: r = a ^ b;
            39: r = 255 - (a | b);
            3:  begin r = (sa >>> 1) & 255; c = a % 2; end
            2:  begin r = a / 2; c = a % 2; end
            default: e = 1;
        endcase
        z = (e == 0 && r == 0);
        n = (r >= 128);
    endtask

    // Reference model, updated on every rising edge
    always @(posedge clk) begin : model
        bit [2:0] p;
        bit la, lb, lo;
        int nst, r, c, z, n, v, e;
        if (rst) begin
            m_state = 0; m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_c = 0; m_z = 0;
            m_n = 0; m_v = 0; m_valid = 0; m_err = 0; m_pend = 0;
            smp0 = 3'b000; smp1 = 3'b000; smp2 = 3'b000;
        end else begin
            p = smp1 & ~smp2;
            la = 1'b0; lb = 1'b0; lo = 1'b0; nst = m_state;
            if (m_state == 0 && p[0]) begin la = 1'b1; nst = 1; end
            else if (m_state == 1 && p[1]) begin lb = 1'b1; nst = 2; end
            else if (m_state == 2 && p[2]) begin lo = 1'b1; nst = 3; end
            else if (m_state == 3) begin
                if (p[0]) begin la = 1'b1; nst = 1; end
                else if (p[1]) lb = 1'b1;
                else if (p[2]) lo = 1'b1;
            end
            if (m_pend != 0) begin
                model_alu(m_a, m_b, m_op, r, c, z, n, v, e);
                m_res = r; m_c = c; m_z = z; m_n = n; m_v = v; m_err = e;
            end
            if (la || lb || lo) m_valid = 0;
            else if (m_pend != 0) m_valid = 1;
            m_pend = ((m_state == 2) && lo) || ((m_state == 3) && (lb || lo));
            if (la) m_a = int'(sw);
            if (lb) m_b = int'(sw);
            if (lo) m_op = int'(sw) % 64;
            m_state = nst;
            smp2 = smp1; smp1 = smp0; smp0 = {btn_op, btn_b, btn_a};
        end
    end

    // Compare all outputs against the model on every falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("result", int'(res), m_res);
            cmp("carry", int'(carry), m_c);
            cmp("zero", int'(zero), m_z);
            cmp("negative", int'(neg), m_n);
            cmp("overflow", int'(ovf), m_v);
            cmp("valid", int'(valid), m_valid);
            cmp("op_err", int'(op_err), m_err);
            cmp("state", int'(state), m_state);
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic press(input bit a, input bit b, input bit op, input int sw_v, input int hold);
        sw = sw_v[7:0];
        btn_a = a; btn_b = b; btn_op = op;
        repeat (hold) step();
        btn_a = 1'b0; btn_b = 1'b0; btn_op = 1'b0;
        repeat (4) step();
    endtask

    int ops [9] = '{32, 34, 36, 37, 38, 39, 3, 2, 17};

    initial begin
        rst = 1'b1; sw = 8'h00; btn_a = 1'b0; btn_b = 1'b0; btn_op = 1'b0;
        step();
        chk_en = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();
        cmp("lit_reset_state", int'(state), 0);
        cmp("lit_reset_valid", int'(valid), 0);
        cmp("lit_reset_result", int'(res), 0);

        // 0x7F + 0x01: signed overflow. Also check OP-to-valid latency.
        press(1, 0, 0, 'h7F, 1);
        press(0, 1, 0, 'h01, 1);
        sw = 8'h20; btn_op = 1'b1;
        step();                      // edge k: button first sampled high
        btn_op = 1'b0;
        step(); step();              // edges k+1, k+2
        cmp("lit_valid_before_k3", int'(valid), 0);
        step();                      // edge k+3
        cmp("lit_valid_at_k3", int'(valid), 1);
        cmp("lit_add_result", int'(res), 'h80);
        cmp("lit_add_carry", int'(carry), 0);
        cmp("lit_add_ovf", int'(ovf), 1);
        cmp("lit_add_neg", int'(neg), 1);
        cmp("lit_add_zero", int'(zero), 0);
        cmp("lit_add_state", int'(state), 3);
        repeat (2) step();

        // 0xFF + 0x01 wraps to zero, then B is reloaded with 0x07 in RESULT
        press(1, 0, 0, 'hFF, 1);
        press(0, 1, 0, 'h01, 1);
        press(0, 0, 1, 'h20, 1);
        cmp("lit_wrap_result", int'(res), 0);
        cmp("lit_wrap_carry", int'(carry), 1);
        cmp("lit_wrap_zero", int'(zero), 1);
        cmp("lit_wrap_ovf", int'(ovf), 0);
        sw = 8'h07; btn_b = 1'b1;
        step();
        btn_b = 1'b0;
        step(); step();
        cmp("lit_reload_valid_low", int'(valid), 0);
        step();
        cmp("lit_reload_valid_high", int'(valid), 1);
        cmp("lit_reload_result", int'(res), 'h06);
        cmp("lit_reload_carry", int'(carry), 1);

        // SUB with a borrow, then SUB with signed overflow
        press(1, 0, 0, 'h05, 1);
        press(0, 1, 0, 'h07, 1);
        press(0, 0, 1, 'h22, 1);
        cmp("lit_sub_result", int'(res), 'hFE);
        cmp("lit_sub_borrow", int'(carry), 1);
        cmp("lit_sub_neg", int'(neg), 1);
        cmp("lit_sub_ovf", int'(ovf), 0);
        press(1, 0, 0, 'h80, 1);
        press(0, 1, 0, 'h01, 1);
        press(0, 0, 1, 'h22, 1);
        cmp("lit_subov_result", int'(res), 'h7F);
        cmp("lit_subov_ovf", int'(ovf), 1);

        // Shifts, then an illegal opcode
        press(1, 0, 0, 'h81, 1);
        press(0, 1, 0, 'h00, 1);
        press(0, 0, 1, 'h03, 1);
        cmp("lit_sra_result", int'(res), 'hC0);
        cmp("lit_sra_carry", int'(carry), 1);
        press(0, 0, 1, 'h02, 1);
        cmp("lit_srl_result", int'(res), 'h40);
        cmp("lit_srl_carry", int'(carry), 1);
        press(0, 0, 1, 'h3F, 1);
        cmp("lit_ill_result", int'(res), 0);
        cmp("lit_ill_err", int'(op_err), 1);
        cmp("lit_ill_valid", int'(valid), 1);
        cmp("lit_ill_zero", int'(zero), 0);

        // Ordering: B and OP are ignored in WAIT_A. A held 20 cycles loads once.
        rst = 1'b1; step(); rst = 1'b0;
        press(0, 1, 0, 'h44, 1);
        cmp("lit_b_in_wait_a", int'(state), 0);
        press(0, 0, 1, 'h20, 1);
        cmp("lit_op_in_wait_a", int'(state), 0);
        sw = 8'h10; btn_a = 1'b1;
        repeat (5) step();
        sw = 8'h33;
        repeat (15) step();
        btn_a = 1'b0;
        repeat (4) step();
        cmp("lit_hold_state", int'(state), 1);
        press(0, 1, 0, 'h01, 1);
        press(0, 0, 1, 'h20, 1);
        cmp("lit_hold_result", int'(res), 'h11);

        // A and B pressed in the same cycle in RESULT: A wins
        press(1, 1, 0, 'h55, 1);
        cmp("lit_prio_state", int'(state), 1);
        cmp("lit_prio_valid", int'(valid), 0);

        // Reset in WAIT_OP, then a fresh sequence
        press(0, 1, 0, 'h02, 1);
        cmp("lit_wait_op", int'(state), 2);
        rst = 1'b1; step(); rst = 1'b0;
        cmp("lit_mid_rst_state", int'(state), 0);
        cmp("lit_mid_rst_result", int'(res), 0);
        cmp("lit_mid_rst_valid", int'(valid), 0);
        press(1, 0, 0, 'h03, 1);
        press(0, 1, 0, 'h04, 1);
        press(0, 0, 1, 'h20, 1);
        cmp("lit_fresh_result", int'(res), 'h07);

        // Randomised phase, checked cycle by cycle against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 1) == 0)
                sw = 8'(($urandom_range(0, 3) << 6) | ops[$urandom_range(0, 8)]);
            else
                sw = 8'($urandom_range(0, 255));
            btn_a  = ($urandom_range(0, 9) == 0);
            btn_b  = ($urandom_range(0, 5) == 0);
            btn_op = ($urandom_range(0, 5) == 0);
            rst    = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0; btn_a = 1'b0; btn_b = 1'b0; btn_op = 1'b0;
        repeat (5) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
